// File: rtl/fetch_unit.sv
// Instruction-fetch stage: steps the PC, reads words from ROM over req/ack, and
// holds each word for the decoder; jumps redirect the PC and flush in-flight fetches.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        REDIRECT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] target_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instrAddr_q;
    logic              firstHold_q, firstHold_d;
    logic              capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            instr_q     <= '0;
            instrAddr_q <= '0;
            firstHold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            firstHold_q <= firstHold_d;
            if (jump) begin
                target_q <= jump_target;
            end
            if (capture) begin
                instr_q     <= rom_data;
                instrAddr_q <= pc_value;
            end
        end
    end

    // A jump always wins; a ROM request in flight must still see its ack before redirecting.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = jump ? REDIRECT : REQ;
            end
            REQ: begin
                if (jump) begin
                    state_d = rom_ack ? REDIRECT : DRAIN;
                end else if (rom_ack) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (jump) begin
                    state_d = REDIRECT;
                end else if (instr_ready) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (rom_ack) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = jump ? REDIRECT : REQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // pc_inc must fire only on the first HOLD cycle so a stalled decoder does not skip words.
    assign firstHold_d = (state_q == REQ) && (state_d == HOLD);

    assign rom_req     = (state_q == REQ) || (state_q == DRAIN);
    assign rom_addr    = rom_req ? pc_value : '0;
    assign pc_inc      = (state_q == HOLD) && firstHold_q;
    assign pc_load     = (state_q == REDIRECT);
    assign pc_in       = pc_load ? target_q : '0;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_addr  = instrAddr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC and ROM environment models, directed
// scenarios, then randomized traffic scored against an address-sequence model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] pcValue;
    logic        pcInc;
    logic        pcLoad;
    logic [15:0] pcIn;
    logic        romReq;
    logic [15:0] romAddr;
    logic        romAck;
    logic [15:0] romData;
    logic [15:0] instr;
    logic [15:0] instrAddr;
    logic        instrValid;
    logic        instrReady;
    logic        jump;
    logic [15:0] jumpTarget;

    int          checkCount = 0;
    int          errorCount = 0;
    int          xferCount  = 0;
    int          waitStates = 0;
    int          waitCnt    = 0;

    logic [15:0] expNext    = 16'h0;
    logic [15:0] lastTarget = 16'h0;
    logic        prevPending = 1'b0;
    logic [15:0] prevAddr   = 16'h0;
    logic        prevHoldWait = 1'b0;
    logic [15:0] prevInstr  = 16'h0;
    logic [15:0] prevInstrAddr = 16'h0;
    logic        seenValid;

    fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_value    (pcValue),
        .pc_inc      (pcInc),
        .pc_load     (pcLoad),
        .pc_in       (pcIn),
        .rom_req     (romReq),
        .rom_addr    (romAddr),
        .rom_ack     (romAck),
        .rom_data    (romData),
        .instr       (instr),
        .instr_addr  (instrAddr),
        .instr_valid (instrValid),
        .instr_ready (instrReady),
        .jump        (jump),
        .jump_target (jumpTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents as a pure function of address; address 0 holds 0x1234.
    function automatic logic [15:0] romFunc(input logic [15:0] a);
        logic [15:0] v;
        v = a * 16'd40503 + 16'h1357;
        return (a == 16'h0) ? 16'h1234 : v;
    endfunction

    // Program counter owned by the environment: load beats increment.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcValue <= 16'h0;
        end else if (pcLoad) begin
            pcValue <= pcIn;
        end else if (pcInc) begin
            pcValue <= pcValue + 16'h1;
        end
    end

    // ROM with a programmable number of wait states; zero waits acks with the request.
    assign romAck  = romReq && (waitCnt >= waitStates);
    assign romData = romAck ? romFunc(romAddr) : 16'hxxxx;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= 0;
        end else if (romReq && !romAck) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the delivered stream is sequential from the last jump target.
    always @(negedge clk) begin
        if (!reset) begin
            expNext      = 16'h0;
            prevPending  = 1'b0;
            prevHoldWait = 1'b0;
        end else begin
            if (pcLoad) checkOutput("pcInTarget", pcIn, lastTarget);
            checkOutput("incLoadExclusive", pcInc & pcLoad, 0);
            if (prevPending && romReq) checkOutput("romAddrStable", romAddr, prevAddr);
            if (prevHoldWait && instrValid) begin
                checkOutput("instrStable", instr, prevInstr);
                checkOutput("instrAddrStable", instrAddr, prevInstrAddr);
            end
            if (instrValid && instrReady) begin
                checkOutput("xferAddr", instrAddr, expNext);
                checkOutput("xferData", instr, romFunc(expNext));
                expNext = instrAddr + 16'h1;
                xferCount++;
            end
            if (jump) begin
                expNext    = jumpTarget;
                lastTarget = jumpTarget;
            end
            prevPending   = romReq && !romAck;
            prevAddr      = romAddr;
            prevHoldWait  = instrValid && !instrReady;
            prevInstr     = instr;
            prevInstrAddr = instrAddr;
        end
    end

    task automatic applyStimulus();
        // Reset state
        reset = 1'b0; jump = 1'b0; jumpTarget = 16'h0; instrReady = 1'b0; waitStates = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstValid", instrValid, 0);
        checkOutput("rstReq", romReq, 0);
        checkOutput("rstInc", pcInc, 0);
        checkOutput("rstLoad", pcLoad, 0);
        checkOutput("rstInstr", instr, 0);
        checkOutput("rstInstrAddr", instrAddr, 0);
        checkOutput("rstPcIn", pcIn, 0);

        // First fetch, zero-wait ROM
        cycle(); reset = 1'b1;
        @(negedge clk);
        checkOutput("idleReq", romReq, 0);
        cycle(); @(negedge clk);
        checkOutput("reqReq", romReq, 1);
        checkOutput("reqAddr", romAddr, 16'h0000);
        checkOutput("reqValid", instrValid, 0);
        cycle(); @(negedge clk);
        checkOutput("holdValid", instrValid, 1);
        checkOutput("holdInstr", instr, 16'h1234);
        checkOutput("holdInstrAddr", instrAddr, 16'h0000);
        checkOutput("holdInc", pcInc, 1);

        // Decoder stalls for five cycles
        repeat (5) begin
            cycle(); @(negedge clk);
            checkOutput("stallInc", pcInc, 0);
            checkOutput("stallReq", romReq, 0);
            checkOutput("stallValid", instrValid, 1);
            checkOutput("stallInstr", instr, 16'h1234);
        end
        checkOutput("pcAfterInc", pcValue, 16'h0001);
        cycle(); instrReady = 1'b1;
        @(negedge clk);
        cycle(); instrReady = 1'b0;
        @(negedge clk);
        checkOutput("nextReqAddr", romAddr, 16'h0001);
        checkOutput("nextReq", romReq, 1);

        // Jump from HOLD
        cycle(); jump = 1'b1; jumpTarget = 16'h0100;
        @(negedge clk);
        checkOutput("hold1Addr", instrAddr, 16'h0001);
        cycle(); jump = 1'b0;
        @(negedge clk);
        checkOutput("jmpLoad", pcLoad, 1);
        checkOutput("jmpPcIn", pcIn, 16'h0100);
        checkOutput("jmpInc", pcInc, 0);
        cycle(); @(negedge clk);
        checkOutput("jmpReq", romReq, 1);
        checkOutput("jmpReqAddr", romAddr, 16'h0100);

        // Three wait states at 0x0010
        cycle(); waitStates = 3; jump = 1'b1; jumpTarget = 16'h0010;
        @(negedge clk);
        checkOutput("jmpInstrAddr", instrAddr, 16'h0100);
        cycle(); jump = 1'b0;
        @(negedge clk);
        checkOutput("ws.load", pcLoad, 1);
        repeat (4) begin
            cycle(); @(negedge clk);
            checkOutput("wsReq", romReq, 1);
            checkOutput("wsAddr", romAddr, 16'h0010);
            checkOutput("wsInc", pcInc, 0);
            checkOutput("wsValid", instrValid, 0);
        end
        cycle(); waitStates = 2; instrReady = 1'b1;
        @(negedge clk);
        checkOutput("wsHoldInc", pcInc, 1);
        checkOutput("wsInstrAddr", instrAddr, 16'h0010);
        checkOutput("wsInstr", instr, romFunc(16'h0010));

        // Jump while a request is outstanding
        cycle(); instrReady = 1'b0; jump = 1'b1; jumpTarget = 16'h0200;
        @(negedge clk);
        checkOutput("drReqAddr", romAddr, 16'h0011);
        cycle(); jump = 1'b0;
        @(negedge clk);
        checkOutput("drainReq", romReq, 1);
        checkOutput("drainAddr", romAddr, 16'h0011);
        checkOutput("drainValid", instrValid, 0);
        cycle(); @(negedge clk);
        checkOutput("drainAckReq", romReq, 1);
        checkOutput("drainAckValid", instrValid, 0);
        cycle(); waitStates = 0;
        @(negedge clk);
        checkOutput("drLoad", pcLoad, 1);
        checkOutput("drPcIn", pcIn, 16'h0200);
        checkOutput("drValid", instrValid, 0);
        cycle(); @(negedge clk);
        checkOutput("drNextAddr", romAddr, 16'h0200);
        cycle(); @(negedge clk);
        checkOutput("drInstrAddr", instrAddr, 16'h0200);
        checkOutput("drInstrValid", instrValid, 1);

        // Randomized traffic
        repeat (3000) begin
            cycle();
            instrReady = ($urandom_range(3) != 0);
            jump       = ($urandom_range(15) == 0);
            jumpTarget = 16'($urandom);
            if (!romReq) waitStates = int'($urandom_range(3));
        end
        cycle(); jump = 1'b0; instrReady = 1'b0; waitStates = 0;
    endtask

    initial begin
        applyStimulus();
        checkOutput("xferActivity", (xferCount > 100) ? 1 : 0, 1);

        // Asynchronous reset in HOLD
        seenValid = 1'b0;
        for (int i = 0; i < 20 && !seenValid; i++) begin
            @(negedge clk);
            seenValid = instrValid;
        end
        checkOutput("reachHold", seenValid, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncValid", instrValid, 0);
        checkOutput("asyncReq", romReq, 0);
        checkOutput("asyncInc", pcInc, 0);
        checkOutput("asyncLoad", pcLoad, 0);
        checkOutput("asyncInstr", instr, 0);
        checkOutput("asyncPcIn", pcIn, 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
